rr_decoder_arbiter: RTL and testbench

RR_DECODER_ARBITER -- requirements
Module: rr_decoder_arbiter

---
 rtl/rr_decoder_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time per grant.
// Outputs are registered; gnt is the one-hot decode of sel, gated by valid.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner; picks the next requester after ptr when req != 0
// GRANT   | owner in sel, cnt counts held cycles up to HOLD_MAX-1
// RELEASE | one dead cycle after a release before arbitration resumes
module rr_decoder_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

    state_t     state, state_d;
    logic [1:0] ptr, ptr_d;
    logic [1:0] sel_d;
    logic [7:0] cnt, cnt_d;
    logic       valid_d;
    logic       timeout_d;
    logic [3:0] gnt_d;

    logic [1:0] pick;
    logic       hold_end;
    logic       owner_req;
    logic       release_now;

    // First requester strictly after p, wrapping around to p itself last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = p + i[1:0];
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        pick = rr_pick(req, ptr);
    end

    assign hold_end    = (cnt == CNT_LAST);
    assign owner_req   = req[sel];
    assign release_now = done | ~owner_req | hold_end;

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        sel_d     = sel;
        cnt_d     = cnt;
        valid_d   = valid;
        timeout_d = 1'b0;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    sel_d   = pick;
                    valid_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = GRANT;
                end else begin
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    valid_d   = 1'b0;
                    ptr_d     = sel;
                    state_d   = RELEASE;
                    // A clean done on the last cycle is a normal release, not a revoke.
                    timeout_d = hold_end & ~done & owner_req;
                end else if (!hold_end) begin
                    cnt_d = cnt + 8'd1;
                end
            end
            RELEASE: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        gnt_d = valid_d ? (4'b0001 << sel_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 2'd3;
            sel     <= 2'd0;
            cnt     <= 8'd0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            gnt     <= 4'b0000;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            sel     <= sel_d;
            cnt     <= cnt_d;
            valid   <= valid_d;
            timeout <= timeout_d;
            gnt     <= gnt_d;
        end
    end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: an abstract ownership model checked
// every cycle, plus hand-computed grant sequences for each scenario.
module tb_rr_decoder_arbiter;

    localparam int HM = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic       done  = 1'b0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       timeout;

    int n_checks = 0;
    int n_err    = 0;

    rr_decoder_arbiter #(.HOLD_MAX(HM)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus, how long they have held it, and how many
    // arbitration opportunities must be skipped after a release.
    int m_owner = -1;
    int m_age   = 0;
    int m_cool  = 0;
    int m_last  = 3;
    int m_sel   = 0;
    bit m_to    = 1'b0;

    function automatic logic [3:0] exp_gnt();
        if (m_owner < 0) return 4'b0000;
        return 4'(1 << m_owner);
    endfunction

    task automatic model_step();
        bit found;
        if (!rst_n) begin
            m_owner = -1; m_age = 0; m_cool = 0; m_last = 3; m_sel = 0; m_to = 1'b0;
        end else if (m_owner >= 0) begin
            if (done || !req[m_owner] || m_age == HM - 1) begin
                m_to    = !done && req[m_owner] && (m_age == HM - 1);
                m_last  = m_owner;
                m_owner = -1;
                m_cool  = 1;
            end else begin
                m_age++;
                m_to = 1'b0;
            end
        end else begin
            m_to = 1'b0;
            if (m_cool > 0) begin
                m_cool--;
            end else if (req != 4'b0000) begin
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && req[(m_last + k) % 4]) begin
                        m_owner = (m_last + k) % 4;
                        found   = 1'b1;
                    end
                end
                m_age = 0;
                m_sel = m_owner;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    logic prev_to = 1'b0;
    initial forever begin
        @(negedge clk);
        chk("cmp_valid", valid, m_owner >= 0);
        chk("cmp_gnt", gnt, exp_gnt());
        chk("cmp_sel", sel, m_sel[1:0]);
        chk("cmp_timeout", timeout, m_to);
        chk("gnt_onehot", $countones(gnt) <= 1, 1);
        if (valid) chk("gnt_decode", gnt, 4'b0001 << sel);
        chk("timeout_single", prev_to & timeout, 0);
        prev_to = timeout;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] grants[5];
        logic [3:0] exp_seq[5];
        int         gaps[5];
        logic [3:0] g[12];
        logic       t[12];
        int         ngr, age, gap, hits;
        logic       prev_valid;

        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin grants[i] = 4'b0000; gaps[i] = 0; end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_valid", valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;

        // All four requesting, done two cycles into each grant
        req = 4'b1111;
        ngr = 0; age = 0; gap = 0; prev_valid = 1'b0;
        for (int cyc = 0; cyc < 40 && ngr < 5; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                chk("first_grant_latency", gnt, 4'b0001);
                chk("model_pin_first", exp_gnt(), 4'b0001);
            end
            if (valid) begin
                if (!prev_valid) begin
                    grants[ngr] = gnt;
                    if (ngr > 0) gaps[ngr] = gap;
                    ngr++;
                    age = 0;
                end
                age++;
                gap = 0;
            end else begin
                gap++;
            end
            done = valid && (age == 2);
            prev_valid = valid;
        end
        chk("s1_grant_count", ngr, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("s1_grant%0d", i), grants[i], exp_seq[i]);
        for (int i = 1; i < 5; i++) chk($sformatf("s1_gap%0d", i), gaps[i], 2);
        done = 1'b0; req = 4'b0000;
        repeat (6) @(negedge clk);

        // Lone requester, never done: hold limit then timeout
        req = 4'b0100;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            g[i] = gnt;
            t[i] = timeout;
        end
        hits = 0;
        for (int i = 1; i <= 8; i++) if (g[i] == 4'b0100) hits++;
        chk("s2_hold_cycles", hits, 8);
        chk("s2_no_early_to", t[8], 0);
        chk("s2_release_gnt", g[9], 4'b0000);
        chk("s2_timeout", t[9], 1);
        chk("s2_timeout_width", t[10], 0);
        chk("s2_gap_gnt", g[10], 4'b0000);
        chk("s2_regrant", g[11], 4'b0100);
        req = 4'b0000;
        repeat (6) @(negedge clk);

        // Owner 1 drops its request; others changing must not disturb it
        req = 4'b0010;
        @(negedge clk);
        chk("s3_grant1", gnt, 4'b0010);
        req = 4'b1111;
        @(negedge clk);
        chk("s3_hold_c2", gnt, 4'b0010);
        @(negedge clk);
        chk("s3_hold_c3", gnt, 4'b0010);
        req = 4'b1101;
        @(negedge clk);
        chk("s3_drop_valid", valid, 0);
        chk("s3_drop_timeout", timeout, 0);
        @(negedge clk);
        chk("s3_idle_gnt", gnt, 4'b0000);
        @(negedge clk);
        chk("s3_next_grant", gnt, 4'b0100);
        req = 4'b0000;
        repeat (6) @(negedge clk);

        // done coincides with the last allowed cycle
        req = 4'b0001;
        hits = 0;
        for (int k = 1; k <= HM; k++) begin
            @(negedge clk);
            if (gnt == 4'b0001) hits++;
            done = (k == HM);
        end
        @(negedge clk);
        done = 1'b0;
        chk("s4_hold_cycles", hits, HM);
        chk("s4_valid", valid, 0);
        chk("s4_timeout", timeout, 0);
        req = 4'b0000;
        repeat (4) @(negedge clk);

        // Async reset mid-grant of requester 3 restores ptr to 3
        req = 4'b1010;
        @(negedge clk);
        chk("s5_grant1", gnt, 4'b0010);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("s5_grant3", gnt, 4'b1000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_rst_gnt", gnt, 4'b0000);
        chk("s5_rst_valid", valid, 0);
        chk("s5_rst_timeout", timeout, 0);
        chk("s5_rst_sel", sel, 0);
        @(negedge clk);
        chk("s5_rst_hold_gnt", gnt, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("s5_after_rst_grant", gnt, 4'b0010);
        chk("s5_after_rst_timeout", timeout, 0);
        req = 4'b0000;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
